// File: rtl/fsm_output_trace_capture.sv
// Change recorder for a control FSM output vector: emits timestamped
// BASELINE / CHANGE / WRAP records into a show-ahead FIFO drained by a
// valid/ready stream, with sticky overflow and a saturating drop counter.
module fsm_output_trace_capture #(
    parameter int unsigned VEC_W = 32,
    parameter int unsigned TS_W  = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          clr,
    input  logic [VEC_W-1:0]              vec_in,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [2+TS_W+VEC_W-1:0]       out_data,
    output logic [$clog2(DEPTH):0]        level,
    output logic                          overflow,
    output logic [7:0]                    drop_cnt
);

    localparam int unsigned DW = 2 + TS_W + VEC_W;
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    localparam logic [1:0] KIND_CHANGE   = 2'b00;
    localparam logic [1:0] KIND_BASELINE = 2'b01;
    localparam logic [1:0] KIND_WRAP     = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        RUN
    } state_t;

    state_t            state_q, state_d;
    logic [TS_W-1:0]   ts_q, ts_d;
    logic [VEC_W-1:0]  prev_q, prev_d;
    logic [DW-1:0]     mem_q [DEPTH];
    logic [DW-1:0]     mem_d [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     count_q, count_d;
    logic              overflow_q, overflow_d;
    logic [7:0]        drop_cnt_q, drop_cnt_d;

    logic              rec_push;
    logic [DW-1:0]     rec_data;
    logic              pop;
    logic              full;
    logic              accept;
    logic              drop;
    logic [AW-1:0]     last_ptr;

    // Next-state and record generation: at most one record per edge.
    always_comb begin
        state_d  = state_q;
        ts_d     = ts_q;
        prev_d   = prev_q;
        rec_push = 1'b0;
        rec_data = '0;
        case (state_q)
            IDLE: begin
                ts_d = '0;
                if (en) state_d = ARM;
            end
            ARM: begin
                rec_push = 1'b1;
                rec_data = {KIND_BASELINE, {TS_W{1'b0}}, vec_in};
                prev_d   = vec_in;
                ts_d     = TS_W'(1);
                state_d  = en ? RUN : IDLE;
            end
            RUN: begin
                if (!en) begin
                    state_d = IDLE;
                    ts_d    = '0;
                end else begin
                    ts_d = ts_q + TS_W'(1);
                    if (vec_in != prev_q) begin
                        rec_push = 1'b1;
                        rec_data = {KIND_CHANGE, ts_q, vec_in};
                        prev_d   = vec_in;
                    end else if (ts_q == '1) begin
                        rec_push = 1'b1;
                        rec_data = {KIND_WRAP, ts_q, prev_q};
                    end
                end
            end
            default: begin
                state_d = IDLE;
                ts_d    = '0;
            end
        endcase
    end

    // FIFO bookkeeping, drop accounting and clear handling.
    always_comb begin
        full     = (count_q == LW'(DEPTH));
        pop      = out_valid && out_ready;
        // A full FIFO still accepts when the head leaves on the same edge;
        // the write slot is the one being vacated.
        accept   = rec_push && (!full || pop);
        drop     = rec_push && full && !pop;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (accept) begin
            mem_d[wr_ptr_q] = rec_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
        case ({accept, pop})
            2'b10:   count_d = count_q + LW'(1);
            2'b01:   count_d = count_q - LW'(1);
            default: count_d = count_q;
        endcase
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (clr) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end
        if (drop) begin
            overflow_d = 1'b1;
            if (clr)                     drop_cnt_d = 8'd1;
            else if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    // Head output; when empty, show the most recently popped record.
    always_comb begin
        last_ptr  = rd_ptr_q - AW'(1);
        out_valid = (count_q != '0);
        out_data  = out_valid ? mem_q[rd_ptr_q] : mem_q[last_ptr];
        level     = count_q;
        overflow  = overflow_q;
        drop_cnt  = drop_cnt_q;
    end

    // State register with asynchronous reset that also flushes the FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ts_q       <= '0;
            prev_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            ts_q       <= ts_d;
            prev_q     <= prev_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
            mem_q      <= mem_d;
        end
    end

endmodule

// File: tb/tb_fsm_output_trace_capture.sv
// Bench for fsm_output_trace_capture: queue-based reference model checked
// every cycle, directed scenarios with literal expectations, random soak.
module tb_fsm_output_trace_capture;

    localparam int VEC_W = 32;
    localparam int TS_W  = 4;
    localparam int DEPTH = 8;
    localparam int DW    = 2 + TS_W + VEC_W;
    localparam int TSMAX = (1 << TS_W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic              clr;
    logic [VEC_W-1:0]  vec_in;
    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     out_data;
    logic [$clog2(DEPTH):0] level;
    logic              overflow;
    logic [7:0]        drop_cnt;

    fsm_output_trace_capture #(
        .VEC_W(VEC_W),
        .TS_W (TS_W),
        .DEPTH(DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .clr      (clr),
        .vec_in   (vec_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .level    (level),
        .overflow (overflow),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [DW-1:0] mk(input int kind, input int ts, input logic [VEC_W-1:0] v);
        logic [1:0]      k;
        logic [TS_W-1:0] t;
        k = kind[1:0];
        t = ts[TS_W-1:0];
        return {k, t, v};
    endfunction

    // Reference model: mode 0 idle, 1 arm, 2 run.
    logic [DW-1:0]    q[$];
    int               m_mode;
    int               m_ts;
    logic [VEC_W-1:0] m_prev;
    bit               m_ovf;
    int               m_drop;
    bit               m_pop, m_full, m_have;
    logic [DW-1:0]    m_rec;

    task automatic model_step();
        if (rst) begin
            q.delete();
            m_mode = 0; m_ts = 0; m_prev = '0; m_ovf = 0; m_drop = 0;
        end else begin
            m_pop  = out_ready && (q.size() > 0);
            m_full = (q.size() == DEPTH);
            m_have = 0;
            m_rec  = '0;
            case (m_mode)
                0: begin
                    m_ts = 0;
                    if (en) m_mode = 1;
                end
                1: begin
                    m_have = 1; m_rec = mk(1, 0, vec_in);
                    m_prev = vec_in; m_ts = 1;
                    m_mode = en ? 2 : 0;
                end
                default: begin
                    if (!en) begin
                        m_mode = 0; m_ts = 0;
                    end else begin
                        if (vec_in != m_prev) begin
                            m_have = 1; m_rec = mk(0, m_ts, vec_in); m_prev = vec_in;
                        end else if (m_ts == TSMAX) begin
                            m_have = 1; m_rec = mk(2, m_ts, m_prev);
                        end
                        m_ts = (m_ts + 1) % (TSMAX + 1);
                    end
                end
            endcase
            if (m_pop) void'(q.pop_front());
            if (clr) begin m_ovf = 0; m_drop = 0; end
            if (m_have) begin
                if (m_full && !m_pop) begin
                    m_ovf = 1;
                    if (m_drop < 255) m_drop++;
                end else begin
                    q.push_back(m_rec);
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            model_step();
        end
    end

    // Every-cycle comparison against the model.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst === 1'b0) begin
                chk("valid", out_valid, q.size() != 0);
                chk("level", level, q.size());
                chk("overflow", overflow, m_ovf);
                chk("drop_cnt", drop_cnt, m_drop);
                if (q.size() != 0) chk("data", out_data, q[0]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; clr = 1'b0; vec_in = '0; out_ready = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        chk("rst_valid", out_valid, 0);
        chk("rst_level", level, 0);
        chk("rst_data", out_data, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_drop", drop_cnt, 0);

        // Baseline record, one-cycle valid pulse.
        en = 1'b1; vec_in = 32'h0000_0030; out_ready = 1'b1;
        step();
        chk("arm_valid", out_valid, 0);
        step();
        chk("base_valid", out_valid, 1);
        chk("base_data", out_data, {2'b01, 4'h0, 32'h0000_0030});
        step();
        chk("base_gone", out_valid, 0);
        chk("base_level", level, 0);

        // Changes at ts 5 and 6.
        repeat (3) step();
        vec_in = 32'h0000_0100;
        step();
        chk("chg5", out_data, {2'b00, 4'h5, 32'h0000_0100});
        vec_in = 32'h0000_0006;
        step();
        chk("chg6", out_data, {2'b00, 4'h6, 32'h0000_0006});
        chk("chg6_level", level, 1);
        step();
        chk("chg_drained", level, 0);

        // WRAP at ts 15, then a change forced at ts 15.
        repeat (7) step();
        step();
        chk("wrap", out_data, {2'b10, 4'hF, 32'h0000_0006});
        repeat (15) step();
        vec_in = 32'h0000_0007;
        step();
        chk("chg15", out_data, {2'b00, 4'hF, 32'h0000_0007});
        step();
        chk("no_wrap", level, 0);

        // Overflow: baseline + 10 changes with consumer stalled.
        en = 1'b0; out_ready = 1'b0;
        step();
        en = 1'b1; vec_in = 32'h0000_00A0;
        step();
        step();
        for (int i = 1; i <= 10; i++) begin
            vec_in = 32'h1000 + i;
            step();
        end
        chk("ovf_level", level, 8);
        chk("ovf_flag", overflow, 1);
        chk("ovf_drops", drop_cnt, 3);
        en = 1'b0; out_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            if (j == 0) chk("drain_head", out_data, {2'b01, 4'h0, 32'h0000_00A0});
            else        chk("drain_head", out_data, mk(0, j, 32'h1000 + j));
            step();
        end
        chk("drain_empty", level, 0);
        chk("drain_ovf_sticky", overflow, 1);

        // clr on the same edge as a drop.
        out_ready = 1'b0; en = 1'b1;
        step();
        step();
        for (int i = 1; i <= 7; i++) begin
            vec_in = 32'h2000 + i;
            step();
        end
        chk("refill_level", level, 8);
        vec_in = 32'h0000_3000; clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_drop_cnt", drop_cnt, 1);
        chk("clr_drop_ovf", overflow, 1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_cnt", drop_cnt, 0);
        chk("clr_ovf", overflow, 0);

        // Full FIFO streaming: push and pop every edge, no drops.
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            vec_in = 32'h4000 + i;
            step();
            chk("stream_level", level, 8);
            chk("stream_drop", drop_cnt, 0);
        end

        // Asynchronous reset mid-drain.
        en = 1'b0;
        repeat (3) step();
        chk("pre_rst_level", level, 5);
        #2 rst = 1'b1;
        #1;
        chk("async_valid", out_valid, 0);
        chk("async_level", level, 0);
        #2 rst = 1'b0;
        en = 1'b1; vec_in = 32'h0000_BEEF;
        step();
        step();
        chk("post_rst_valid", out_valid, 1);
        chk("post_rst_base", out_data, {2'b01, 4'h0, 32'h0000_BEEF});

        // Drop counter saturation.
        out_ready = 1'b0;
        for (int i = 0; i < 270; i++) begin
            vec_in = vec_in + 32'd1;
            step();
        end
        chk("sat_drop", drop_cnt, 255);
        en = 1'b0; clr = 1'b1;
        step();
        clr = 1'b0;
        chk("sat_clr", drop_cnt, 0);

        // Random soak checked by the model each cycle.
        for (int i = 0; i < 1500; i++) begin
            en = ($urandom_range(0, 24) != 0);
            if ($urandom_range(0, 2) == 0) vec_in = vec_in ^ (32'h1 << $urandom_range(0, 31));
            if (i % 500 < 150) out_ready = ($urandom_range(0, 4) == 0);
            else               out_ready = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 60) == 0);
            if ($urandom_range(0, 700) == 0) begin
                #2 rst = 1'b1;
                #2 rst = 1'b0;
            end
            step();
        end
        clr = 1'b0;

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
